// File: rtl/qspi_resp_pkg.sv
// Shared definitions for the QSPI flash responder: opcodes, FSM states, data
// modes and the opcode decoder used when the 8th command bit is sampled.
package qspi_resp_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    // Accepted but ignored opcodes: no response, no error.
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_RES   = 8'hAB;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } state_e;

    typedef enum logic [1:0] {
        ModeSingle,
        ModeQuad,
        ModeId,
        ModeStatus
    } data_mode_e;

    typedef struct packed {
        state_e     next;
        data_mode_e mode;
        logic       dummy;
        logic       err;
    } decode_t;

    function automatic decode_t decode_op(input logic [7:0] op);
        decode_t d;
        d.next  = StIgnore;
        d.mode  = ModeSingle;
        d.dummy = 1'b0;
        d.err   = 1'b0;
        case (op)
            OP_READ:  d.next = StAddr;
            OP_FREAD: begin
                d.next  = StAddr;
                d.dummy = 1'b1;
            end
            OP_QREAD: begin
                d.next  = StAddr;
                d.mode  = ModeQuad;
                d.dummy = 1'b1;
            end
            OP_RDID: begin
                d.next = StData;
                d.mode = ModeId;
            end
            OP_RDSR: begin
                d.next = StData;
                d.mode = ModeStatus;
            end
            OP_WREN, OP_RSTEN, OP_RST, OP_RES: ;
            default:  d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qspi_resp_sync.sv
// Input synchronizer and edge detector for the SPI pins.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   sck, cs_n, dq     - asynchronous pad inputs
//   sck_rise/sck_fall - registered one-clk pulses on synchronized SCK edges
//   cs_fall/cs_rise   - registered one-clk pulses on synchronized CS_n edges
//   dq_s              - synchronized DQ, aligned with the edge pulses
// CS_n synchronizer resets to 0 so a transaction already in progress when
// reset drops never produces a cs_fall; only a real high-to-low edge does.
module qspi_resp_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] dq,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic [3:0] dq_s
);

    logic [SYNC_STAGES-1:0]      sck_q;
    logic [SYNC_STAGES-1:0]      cs_q;
    logic [SYNC_STAGES-1:0][3:0] dq_q;
    logic                        sck_prev_q;
    logic                        cs_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q      <= '0;
            cs_q       <= '0;
            dq_q       <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
            sck_rise   <= 1'b0;
            sck_fall   <= 1'b0;
            cs_fall    <= 1'b0;
            cs_rise    <= 1'b0;
            dq_s       <= '0;
        end else begin
            sck_q[0] <= sck;
            cs_q[0]  <= cs_n;
            dq_q[0]  <= dq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_q[i] <= sck_q[i-1];
                cs_q[i]  <= cs_q[i-1];
                dq_q[i]  <= dq_q[i-1];
            end
            sck_prev_q <= sck_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_q[SYNC_STAGES-1];
            sck_rise   <= sck_q[SYNC_STAGES-1] & ~sck_prev_q;
            sck_fall   <= ~sck_q[SYNC_STAGES-1] & sck_prev_q;
            cs_rise    <= cs_q[SYNC_STAGES-1] & ~cs_prev_q;
            cs_fall    <= ~cs_q[SYNC_STAGES-1] & cs_prev_q;
            // Delayed one extra stage so it matches the registered pulses.
            dq_s       <= dq_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/qspi_flash_responder.sv
// SPI NOR boot-flash emulator (mode 0) serving reads from a byte-wide
// synchronous memory. Oversamples SCK/CS_n/DQ in the clk domain.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   spi_sck, spi_cs_n     - SPI clock and active-low chip select
//   spi_dq_i/o/oe         - pad inputs, output values, output enables
//   mem_rd, mem_addr      - one-clk read strobe and byte address
//   mem_rdata             - read data, valid 1 clk after mem_rd
//   busy                  - transaction active
//   cmd_err               - one-clk pulse on an unsupported opcode
module qspi_flash_responder
    import qspi_resp_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic [3:0]        spi_dq_i,
    output logic [3:0]        spi_dq_o,
    output logic [3:0]        spi_dq_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic [3:0] dq_s;
    logic       dq0;
    logic       unused_dq;

    qspi_resp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (spi_sck),
        .cs_n     (spi_cs_n),
        .dq       (spi_dq_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .dq_s     (dq_s)
    );

    assign dq0       = dq_s[0];
    assign unused_dq = ^dq_s[3:1];

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [6:0]        op_q, op_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    data_mode_e        mode_q, mode_d;
    logic              dummy_q, dummy_d;
    logic [7:0]        sr_q, sr_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              load_q, load_d;
    logic [3:0]        dq_o_q, dq_o_d, oe_q, oe_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d, cmd_err_q, cmd_err_d;

    decode_t           dec;
    logic [ADDR_W-1:0] addr_shift;
    logic              byte_last;

    // Only the low ADDR_W address bits are kept; higher bits shift out.
    assign dec        = decode_op({op_q, dq0});
    assign addr_shift = {addr_q, dq0};
    assign byte_last  = (mode_q == ModeQuad) ? (cnt_q == 5'd1) : (cnt_q == 5'd7);

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (cs_fall) state_d = StCmd;
                StCmd:   if (sck_rise && cnt_q == 5'd7) state_d = dec.next;
                StAddr: begin
                    if (sck_rise && cnt_q == 5'd23) begin
                        state_d = (dummy_q && DUMMY_CYCLES != 0) ? StDummy : StData;
                    end
                end
                StDummy: begin
                    if (sck_rise && cnt_q == 5'(DUMMY_CYCLES - 1)) state_d = StData;
                end
                default: ;
            endcase
        end
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        dummy_d    = dummy_q;
        sr_d       = sr_q;
        id_idx_d   = id_idx_q;
        dq_o_d     = dq_o_q;
        oe_d       = oe_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        cmd_err_d  = 1'b0;
        load_d     = mem_rd_q;
        if (cs_rise) begin
            cnt_d  = '0;
            oe_d   = '0;
            dq_o_d = '0;
            load_d = 1'b0;
        end else begin
            // Memory data lands one clk after the strobe; well before the next fall.
            if (load_q) sr_d = mem_rdata;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        oe_d  = '0;
                        cnt_d = sck_rise ? 5'd1 : 5'd0;
                        op_d  = sck_rise ? {6'd0, dq0} : 7'd0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        op_d  = {op_q[5:0], dq0};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d     = '0;
                            mode_d    = dec.mode;
                            dummy_d   = dec.dummy;
                            cmd_err_d = dec.err;
                            sr_d      = (dec.mode == ModeId) ? id_byte(2'd0) : 8'h00;
                            id_idx_d  = 2'd1;
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        addr_d = addr_shift[ADDR_W-2:0];
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d      = '0;
                            mem_addr_d = addr_shift;
                            mem_rd_d   = 1'b1;
                        end
                    end
                end
                StDummy: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'(DUMMY_CYCLES - 1)) cnt_d = '0;
                    end
                end
                StData: begin
                    if (sck_fall) begin
                        if (mode_q == ModeQuad) begin
                            dq_o_d = sr_q[7:4];
                            oe_d   = 4'b1111;
                            sr_d   = {sr_q[3:0], 4'h0};
                        end else begin
                            dq_o_d = {2'b00, sr_q[7], 1'b0};
                            oe_d   = 4'b0010;
                            sr_d   = {sr_q[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (byte_last) begin
                            cnt_d = '0;
                            unique case (mode_q)
                                ModeSingle, ModeQuad: begin
                                    mem_addr_d = mem_addr_q + 1'b1;
                                    mem_rd_d   = 1'b1;
                                end
                                ModeId: begin
                                    sr_d     = id_byte(id_idx_q);
                                    id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                                end
                                default: sr_d = 8'h00;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            mode_q     <= ModeSingle;
            dummy_q    <= 1'b0;
            sr_q       <= '0;
            id_idx_q   <= '0;
            load_q     <= 1'b0;
            dq_o_q     <= '0;
            oe_q       <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            dummy_q    <= dummy_d;
            sr_q       <= sr_d;
            id_idx_q   <= id_idx_d;
            load_q     <= load_d;
            dq_o_q     <= dq_o_d;
            oe_q       <= oe_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign spi_dq_o  = dq_o_q;
    assign spi_dq_oe = oe_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;

    localparam int unsigned ADDR_W = 16;
    localparam logic [23:0] JEDEC  = 24'hEF4016;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              spi_sck = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic [3:0]        spi_dq_i = 4'h0;
    logic [3:0]        spi_dq_o, spi_dq_oe;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy, cmd_err;

    qspi_flash_responder #(
        .ADDR_W       (ADDR_W),
        .JEDEC_ID     (JEDEC),
        .DUMMY_CYCLES (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_dq_i  (spi_dq_i),
        .spi_dq_o  (spi_dq_o),
        .spi_dq_oe (spi_dq_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Flash image: synchronous byte-wide memory
    logic [7:0] mem [65536];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Passive monitor, sole writer of these counters
    logic [15:0] rd_log[$];
    int          err_cycles = 0;
    int          oe_cycles = 0;
    int          busy_cycles = 0;
    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (cmd_err) err_cycles++;
        if (spi_dq_oe != 4'h0) oe_cycles++;
        if (busy) busy_cycles++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what a flash returns for byte k of a transaction
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr,
                                              input int k);
        logic [31:0] id_word;
        id_word = {JEDEC, 8'hFF};
        case (op)
            8'h03, 8'h0B, 8'h6B: return mem[16'(addr + 24'(k))];
            8'h9F: return (k < 3) ? id_word[31-8*k -: 8] : 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    logic [3:0] s_dq, s_oe;
    logic [7:0] rx[$];
    int         oe_wrong;
    int         dummy_oe;

    task automatic sck_cycle(input logic mosi);
        spi_dq_i = {3'b000, mosi};
        repeat (8) @(negedge clk);
        spi_sck = 1'b1;
        s_dq = spi_dq_o;
        s_oe = spi_dq_oe;
        repeat (8) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sck_cycle(v[i]);
    endtask

    task automatic begin_txn(input logic [7:0] op);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        send_bits({24'h0, op}, 8);
    endtask

    task automatic end_txn();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic read_bytes(input bit quad, input int n);
        logic [7:0] b;
        rx.delete();
        oe_wrong = 0;
        for (int k = 0; k < n; k++) begin
            b = 8'h00;
            for (int j = 0; j < (quad ? 2 : 8); j++) begin
                sck_cycle(1'b0);
                b = quad ? {b[3:0], s_dq} : {b[6:0], s_dq[1]};
                if (s_oe !== (quad ? 4'hF : 4'h2)) oe_wrong++;
            end
            rx.push_back(b);
        end
    endtask

    task automatic run_read(input logic [7:0] op, input logic [23:0] addr, input int n,
                            input bit close, input string tag);
        bit has_addr, has_dummy;
        has_addr  = (op == 8'h03 || op == 8'h0B || op == 8'h6B);
        has_dummy = (op == 8'h0B || op == 8'h6B);
        begin_txn(op);
        if (has_addr) send_bits({8'h00, addr}, 24);
        dummy_oe = 0;
        if (has_dummy) begin
            for (int i = 0; i < 8; i++) begin
                sck_cycle(1'b0);
                if (s_oe !== 4'h0) dummy_oe++;
            end
        end
        read_bytes(op == 8'h6B, n);
        if (close) end_txn();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s byte%0d", tag, k), 32'(rx[k]), 32'(model_byte(op, addr, k)));
        end
        check({tag, " data oe"}, oe_wrong, 0);
        if (has_dummy) check({tag, " dummy oe"}, dummy_oe, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dq_o"}, 32'(spi_dq_o), 0);
        check({tag, " dq_oe"}, 32'(spi_dq_oe), 0);
        check({tag, " mem_rd"}, 32'(mem_rd), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " cmd_err"}, 32'(cmd_err), 0);
    endtask

    initial begin
        int r0, e0, o0, b0, n;
        logic [7:0]  op;
        logic [23:0] a;
        logic [7:0]  ops [5];
        ops = '{8'h03, 8'h0B, 8'h6B, 8'h9F, 8'h05};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h3C;

        // Reset state
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (8) @(negedge clk);

        // Single read of four bytes at 0x100
        r0 = rd_log.size();
        run_read(8'h03, 24'h000100, 4, 1'b1, "read");
        check("read word", {rx[0], rx[1], rx[2], rx[3]}, 32'h11223344);
        check("read rd count>=4", 32'(rd_log.size() - r0 >= 4), 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("read rd addr%0d", i), 32'(rd_log[r0 + i]), 32'h100 + i);

        // Quad read with address wrap; high address bits beyond ADDR_W are dropped
        r0 = rd_log.size();
        run_read(8'h6B, 24'h12FFFF, 2, 1'b0, "qread");
        check("qread word", {rx[0], rx[1]}, 32'h0000A53C);
        check("qread rd addr0", 32'(rd_log[r0]), 32'hFFFF);
        check("qread rd addr1", 32'(rd_log[r0 + 1]), 32'h0000);
        // Abort in DATA: oe drops the clk after CS_n rise is detected
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("qabort oe held", 32'(spi_dq_oe), 32'hF);
        @(negedge clk);
        check("qabort oe off", 32'(spi_dq_oe), 0);
        check("qabort busy", 32'(busy), 0);
        repeat (16) @(negedge clk);

        // JEDEC ID: no memory reads
        r0 = rd_log.size();
        run_read(8'h9F, 24'h0, 5, 1'b1, "rdid");
        check("rdid bytes", {rx[0], rx[1], rx[2], rx[3]}, 32'hEF4016FF);
        check("rdid no mem_rd", rd_log.size() - r0, 0);

        // Unsupported opcode: single cmd_err pulse, no driving
        e0 = err_cycles;
        o0 = oe_cycles;
        begin_txn(8'h42);
        repeat (8) @(negedge clk);
        check("bad op err pulse", err_cycles - e0, 1);
        send_bits(32'hFFFF, 16);
        check("bad op oe", oe_cycles - o0, 0);
        end_txn();
        run_read(8'h05, 24'h0, 2, 1'b1, "rdsr");
        // Accepted no-op: no error
        e0 = err_cycles;
        begin_txn(8'h06);
        end_txn();
        check("wren no err", err_cycles - e0, 0);

        // Abort after 13 bits, then a clean read
        begin_txn(8'h03);
        send_bits(32'h0, 5);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort13 busy held", 32'(busy), 1);
        @(negedge clk);
        check("abort13 busy off", 32'(busy), 0);
        check("abort13 oe", 32'(spi_dq_oe), 0);
        repeat (16) @(negedge clk);
        run_read(8'h03, 24'h000010, 2, 1'b1, "after abort");

        // Randomized transactions against the model
        for (int t = 0; t < 6; t++) begin
            op = ops[$urandom_range(0, 4)];
            a  = 24'($urandom);
            n  = $urandom_range(1, 4);
            run_read(op, a, n, 1'b1, $sformatf("rand%0d op%h", t, op));
        end

        // Reset mid-DATA: back to reset values, silent until CS_n toggles
        run_read(8'h03, 24'h000200, 1, 1'b0, "pre-reset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midreset");
        r0 = rd_log.size();
        o0 = oe_cycles;
        b0 = busy_cycles;
        send_bits(32'h0, 16);
        check("postreset oe", oe_cycles - o0, 0);
        check("postreset busy", busy_cycles - b0, 0);
        check("postreset rd", rd_log.size() - r0, 0);
        end_txn();
        run_read(8'h0B, 24'h00ABCD, 2, 1'b1, "postreset read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case something stalls
    initial begin
        #5ms;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
